// File: rtl/hubris_dump_pkg.sv
// Shared definitions for the Hubris end-of-run state dumper.
//   - dump_state_e : FSM state encoding of the dumper
//   - HEADER_BYTE_DEFAULT : first byte of every frame
//   - CSUM_W : width of the optional frame checksum
//   - frame_len() : number of bytes in one frame for a given configuration
// Optional feature macro: HUBRIS_DUMP_CHECKSUM_EN (adds a trailing checksum byte).
package hubris_dump_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_PC,
        ST_REG_LOAD,
        ST_REG_SEND,
        ST_MEM_FETCH,
        ST_MEM_SEND,
`ifdef HUBRIS_DUMP_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE
    } dump_state_e;

    localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;
    localparam int         CSUM_W              = 8;

    // Header + pc word + one word per register + memory bytes (+ checksum).
    function automatic int frame_len(input int reg_number, input int dmem_bytes);
        int len;
        len = 1 + 4 + 4 * reg_number + dmem_bytes;
`ifdef HUBRIS_DUMP_CHECKSUM_EN
        len = len + 1;
`endif
        return len;
    endfunction

endpackage

// File: rtl/hubris_dump_byte_tx.sv
// Output register stage of the state dumper.
// Holds one byte (tx_data/tx_last) and its valid flag; the byte stays stable
// until the sink takes it. tx_valid is purely registered, so it never depends
// combinationally on tx_ready.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   load             : capture load_data/load_last and raise tx_valid
//   load_data/_last  : byte to send and its end-of-frame flag
//   tx_ready         : sink ready
//   tx_data/_valid/_last : stream outputs
//   accepted         : pulse, the held byte transfers on this cycle
// The owner must only assert load when the stage is empty or accepted=1.
module hubris_dump_byte_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       load_last,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       tx_last,
    output logic       accepted
);
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;

    assign accepted = valid_q & tx_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
            last_d  = load_last;
        end else if (accepted) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign tx_data  = data_q;
    assign tx_valid = valid_q;
    assign tx_last  = last_q;

endmodule

// File: rtl/hubris_state_dumper.sv
// Hubris end-of-run state dumper.
// On the first halt after reset it streams one frame:
//   HEADER_BYTE, pc (4 bytes LE), x0..x(REG_NUMBER-1) (4 bytes LE each),
//   dmem[0..DMEM_BYTES-1], and with HUBRIS_DUMP_CHECKSUM_EN a mod-256 sum
//   of all preceding bytes. Then it sits in DONE until reset.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   halt, pc                   : core halt line and program counter
//   rf_rd_addr / rf_rd_data    : register file port (combinational read)
//   dm_rd_addr / dm_rd_data    : data memory port (1-cycle read latency)
//   tx_data/tx_valid/tx_ready/tx_last : byte stream
//   busy, done                 : dump in progress / frame sent (sticky)
// Optional feature macro: HUBRIS_DUMP_CHECKSUM_EN.
module hubris_state_dumper
    import hubris_dump_pkg::*;
#(
    parameter int         REG_NUMBER  = 32,
    parameter int         DMEM_BYTES  = 1024,
    parameter int         DMEM_ADDR_W = 10,
    parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   halt,
    input  logic [31:0]            pc,
    output logic [4:0]             rf_rd_addr,
    input  logic [31:0]            rf_rd_data,
    output logic [DMEM_ADDR_W-1:0] dm_rd_addr,
    input  logic [7:0]             dm_rd_data,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    output logic                   busy,
    output logic                   done
);
    localparam logic [4:0]             REG_LAST = 5'(REG_NUMBER - 1);
    localparam logic [DMEM_ADDR_W-1:0] MEM_LAST = DMEM_ADDR_W'(DMEM_BYTES - 1);

    dump_state_e            state_q, state_d;
    logic [31:0]            shift_q, shift_d;     // pc snapshot, then register word
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [4:0]             reg_idx_q, reg_idx_d;
    logic [DMEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic                   loaded_q, loaded_d;   // current byte handed to tx stage
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
`ifdef HUBRIS_DUMP_CHECKSUM_EN
    logic [CSUM_W-1:0]      csum_q, csum_d;
`endif

    logic       load;
    logic [7:0] load_data;
    logic       load_last;
    logic       accepted;

    hubris_dump_byte_tx u_byte_tx (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .accepted  (accepted)
    );

    // Every byte takes two phases: hand it to the tx stage (loaded=0), then
    // wait for its accepted pulse (loaded=1) before advancing.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        reg_idx_d  = reg_idx_q;
        mem_addr_d = mem_addr_q;
        loaded_d   = loaded_q;
        busy_d     = busy_q;
        done_d     = done_q;
        load       = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
`ifdef HUBRIS_DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (halt && !done_q) begin
                    state_d    = ST_HDR;
                    shift_d    = pc;
                    byte_cnt_d = 2'd0;
                    loaded_d   = 1'b0;
                    busy_d     = 1'b1;
`ifdef HUBRIS_DUMP_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            ST_HDR: begin
                if (!loaded_q) begin
                    load      = 1'b1;
                    load_data = HEADER_BYTE;
                    loaded_d  = 1'b1;
                end else if (accepted) begin
                    loaded_d = 1'b0;
                    state_d  = ST_PC;
                end
            end
            ST_PC, ST_REG_SEND: begin
                if (!loaded_q) begin
                    load      = 1'b1;
                    load_data = shift_q[7:0];
                    loaded_d  = 1'b1;
                end else if (accepted) begin
                    loaded_d   = 1'b0;
                    shift_d    = {8'h00, shift_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (state_q == ST_PC) begin
                            state_d = ST_REG_LOAD;
                        end else if (reg_idx_q == REG_LAST) begin
                            state_d    = ST_MEM_FETCH;
                            reg_idx_d  = 5'd0;
                            mem_addr_d = '0;
                        end else begin
                            state_d   = ST_REG_LOAD;
                            reg_idx_d = reg_idx_q + 5'd1;
                        end
                    end
                end
            end
            ST_REG_LOAD: begin
                shift_d = rf_rd_data;
                state_d = ST_REG_SEND;
            end
            ST_MEM_FETCH: begin
                // Address is already on dm_rd_addr; data is valid next cycle.
                state_d = ST_MEM_SEND;
            end
            ST_MEM_SEND: begin
                if (!loaded_q) begin
                    load      = 1'b1;
                    load_data = dm_rd_data;
                    loaded_d  = 1'b1;
`ifdef HUBRIS_DUMP_CHECKSUM_EN
                    load_last = 1'b0;
`else
                    load_last = (mem_addr_q == MEM_LAST);
`endif
                end else if (accepted) begin
                    loaded_d = 1'b0;
                    if (mem_addr_q == MEM_LAST) begin
`ifdef HUBRIS_DUMP_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        mem_addr_d = mem_addr_q + 1'b1;
                        state_d    = ST_MEM_FETCH;
                    end
                end
            end
`ifdef HUBRIS_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (!loaded_q) begin
                    load      = 1'b1;
                    load_data = csum_q;
                    load_last = 1'b1;
                    loaded_d  = 1'b1;
                end else if (accepted) begin
                    loaded_d = 1'b0;
                    state_d  = ST_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                // Terminal until reset; halt is ignored.
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef HUBRIS_DUMP_CHECKSUM_EN
        // Each frame byte is loaded exactly once, so summing at load time
        // covers every byte ahead of the checksum itself.
        if (load) begin
            csum_d = csum_q + load_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= 32'd0;
            byte_cnt_q <= 2'd0;
            reg_idx_q  <= 5'd0;
            mem_addr_q <= '0;
            loaded_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef HUBRIS_DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            reg_idx_q  <= reg_idx_d;
            mem_addr_q <= mem_addr_d;
            loaded_q   <= loaded_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef HUBRIS_DUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign rf_rd_addr = reg_idx_q;
    assign dm_rd_addr = mem_addr_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
